// File: rtl/zap_mac_tiled.sv
// zap_mac_tiled: iterative tiled multiply / multiply-accumulate unit, one tile pair per cycle.
// Define ZAP_MAC_SAT_EN to build the saturating accumulate path.
module zap_mac_tiled #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TILE_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_clear,
  input  logic                  i_stall,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [1:0]            i_op,
  input  logic                  i_sat,
  input  logic [DATA_W-1:0]     i_a,
  input  logic [DATA_W-1:0]     i_b,
  input  logic [2*DATA_W-1:0]   i_acc,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*DATA_W-1:0]   o_rd,
  output logic                  o_sat,
  output logic                  o_busy
);
  localparam int unsigned N      = DATA_W / TILE_W;
  localparam int unsigned NN     = N * N;
  localparam int unsigned CNT_W  = $clog2(NN + 1);
  localparam int unsigned RES_W  = 2 * DATA_W;
  localparam int unsigned PROD_W = 2 * TILE_W + 2;
  localparam int unsigned SH_W   = $clog2(RES_W);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [RES_W-1:0]         sum_q;
  logic signed [PROD_W-1:0] prod_q;
  logic [SH_W-1:0]          sh_q;
  logic [1:0]               op_q;
  logic [DATA_W-1:0]        a_q, b_q;
  logic [RES_W-1:0]         acc_q;

  logic accept;
  logic run;

  assign o_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & i_ready);
  assign run     = ~i_clear & ~i_stall;
  assign accept  = i_valid & o_ready & run;

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; clear beats stall
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = S_IDLE;
    end else if (!i_stall) begin
      case (state_q)
        S_IDLE: if (accept) state_d = S_MUL;
        S_MUL:  if (cnt_q == CNT_W'(NN)) state_d = S_ACC;
        S_ACC:  state_d = S_DONE;
        S_DONE: begin
          if (accept)       state_d = S_MUL;
          else if (i_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Tile pair selection and the multiplier input stage
  int unsigned              j_idx, k_idx;
  logic [TILE_W-1:0]        slice_a, slice_b;
  logic signed [TILE_W:0]   tile_a, tile_b;
  logic signed [PROD_W-1:0] prod_c;
  logic [SH_W-1:0]          sh_c;

  always_comb begin
    j_idx = 0;
    k_idx = 0;
    if (32'(cnt_q) < NN) begin
      j_idx = 32'(cnt_q) / N;
      k_idx = 32'(cnt_q) % N;
    end
    slice_a = a_q[j_idx*TILE_W +: TILE_W];
    slice_b = b_q[k_idx*TILE_W +: TILE_W];
    tile_a  = {op_q[0] & (j_idx == N - 1) & slice_a[TILE_W-1], slice_a};
    tile_b  = {op_q[0] & (k_idx == N - 1) & slice_b[TILE_W-1], slice_b};
    prod_c  = PROD_W'(tile_a) * PROD_W'(tile_b);
    sh_c    = SH_W'((j_idx + k_idx) * TILE_W);
  end

  logic [RES_W-1:0] pp_ext, pp_shifted;
  assign pp_ext     = RES_W'(prod_q);
  assign pp_shifted = pp_ext << sh_q;

  // Final accumulate, with optional clamp
`ifdef ZAP_MAC_SAT_EN
  logic             sat_q;
  logic [RES_W:0]   add_c;
  logic [RES_W-1:0] res_c;
  logic             sat_c;

  always_comb begin
    add_c = {1'b0, sum_q} + {1'b0, acc_q};
    res_c = sum_q;
    sat_c = 1'b0;
    if (op_q[1]) begin
      res_c = add_c[RES_W-1:0];
      if (sat_q) begin
        if (op_q[0]) begin
          if ((sum_q[RES_W-1] == acc_q[RES_W-1]) && (add_c[RES_W-1] != sum_q[RES_W-1])) begin
            res_c = {sum_q[RES_W-1], {(RES_W-1){~sum_q[RES_W-1]}}};
            sat_c = 1'b1;
          end
        end else if (add_c[RES_W]) begin
          res_c = '1;
          sat_c = 1'b1;
        end
      end
    end
  end
`else
  logic             sat_unused;
  logic [RES_W-1:0] res_c;

  assign sat_unused = i_sat;
  assign o_sat      = 1'b0;

  always_comb begin
    res_c = sum_q;
    if (op_q[1]) res_c = sum_q + acc_q;
  end
`endif

  // Operand capture, counter, pipelined product and running sum
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      sum_q  <= '0;
      prod_q <= '0;
      sh_q   <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
`ifdef ZAP_MAC_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else if (run) begin
      prod_q <= prod_c;
      sh_q   <= sh_c;
      if (accept) begin
        op_q  <= i_op;
        a_q   <= i_a;
        b_q   <= i_b;
        acc_q <= i_acc;
`ifdef ZAP_MAC_SAT_EN
        sat_q <= i_sat;
`endif
        cnt_q <= '0;
        sum_q <= '0;
      end else if (state_q == S_MUL) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q != '0) sum_q <= sum_q + pp_shifted;
      end
    end
  end

  // Registered outputs; result latched on the ACC -> DONE edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
      o_rd    <= '0;
`ifdef ZAP_MAC_SAT_EN
      o_sat   <= 1'b0;
`endif
    end else begin
      o_valid <= (state_d == S_DONE);
      o_busy  <= (state_d != S_IDLE);
      if (run && (state_q == S_ACC)) begin
        o_rd  <= res_c;
`ifdef ZAP_MAC_SAT_EN
        o_sat <= sat_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_zap_mac_tiled.sv
// Directed bench for zap_mac_tiled: scoreboard of expected results, immediate-assertion checks.
// Expectations follow ZAP_MAC_SAT_EN when the bench is built with it.
module tb_zap_mac_tiled;
  typedef struct packed {
    logic [63:0] rd;
    logic        sat;
  } exp_t;

  logic        i_clk   = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [1:0]  i_op    = '0;
  logic        i_sat   = 1'b0;
  logic [31:0] i_a     = '0;
  logic [31:0] i_b     = '0;
  logic [63:0] i_acc   = '0;
  logic        o_ready, o_valid, o_sat, o_busy;
  logic [63:0] o_rd;

  logic        s_valid = 1'b0;
  logic        s_iready = 1'b0;
  logic [1:0]  s_op    = '0;
  logic [23:0] s_a     = '0;
  logic [23:0] s_b     = '0;
  logic [47:0] s_acc   = '0;
  logic        s_ready, s_ovalid, s_osat, s_busy;
  logic [47:0] s_rd;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  exp_t sbq[$];

  zap_mac_tiled dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_stall(i_stall),
    .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op), .i_sat(i_sat),
    .i_a(i_a), .i_b(i_b), .i_acc(i_acc), .o_valid(o_valid), .i_ready(i_ready),
    .o_rd(o_rd), .o_sat(o_sat), .o_busy(o_busy)
  );

  zap_mac_tiled #(.DATA_W(24), .TILE_W(8)) dut_s (
    .i_clk(i_clk), .i_reset(i_reset), .i_clear(i_clear), .i_stall(i_stall),
    .i_valid(s_valid), .o_ready(s_ready), .i_op(s_op), .i_sat(i_sat),
    .i_a(s_a), .i_b(s_b), .i_acc(s_acc), .o_valid(s_ovalid), .i_ready(s_iready),
    .o_rd(s_rd), .o_sat(s_osat), .o_busy(s_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] rd, input logic sat);
    exp_t e;
    e.rd  = rd;
    e.sat = sat;
    return e;
  endfunction

  // Reference: full-width product, then wrap or clamp the accumulate
  function automatic exp_t model(input logic [1:0] op, input logic sat, input logic [31:0] a,
                                 input logic [31:0] b, input logic [63:0] acc);
    logic [63:0] p;
    logic [64:0] s;
    exp_t        e;
    if (op[0]) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    else       p = {32'b0, a} * {32'b0, b};
    e.sat = 1'b0;
    e.rd  = p;
    if (op[1]) begin
      s    = {1'b0, p} + {1'b0, acc};
      e.rd = s[63:0];
`ifdef ZAP_MAC_SAT_EN
      if (sat) begin
        if (op[0]) begin
          if (p[63] == acc[63] && s[63] != p[63]) begin
            e.rd  = p[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            e.sat = 1'b1;
          end
        end else if (s[64]) begin
          e.rd  = '1;
          e.sat = 1'b1;
        end
      end
`endif
    end
    return e;
  endfunction

  // Drive one request and return at the negedge after the accepting edge
  task automatic send(input logic [1:0] op, input logic sat, input logic [31:0] a,
                      input logic [31:0] b, input logic [63:0] acc);
    int n = 0;
    @(negedge i_clk);
    i_valid = 1'b1; i_op = op; i_sat = sat; i_a = a; i_b = b; i_acc = acc;
    #1;
    while (!o_ready && n < 50) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    check("send_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    acc_cyc = cyc;
    i_valid = 1'b0;
    i_op = 2'($urandom); i_sat = 1'($urandom); i_a = $urandom; i_b = $urandom;
    i_acc = {$urandom, $urandom};
  endtask

  task automatic get_result(input int exp_lat, input string tag);
    int   n = 0;
    exp_t e;
    while (!o_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check({tag, "_valid"}, 64'(o_valid), 64'd1);
    check({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(exp_lat));
    e = (sbq.size() > 0) ? sbq.pop_front() : mk('x, 1'bx);
    check({tag, "_rd"}, o_rd, e.rd);
    check({tag, "_sat"}, 64'(o_sat), 64'(e.sat));
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check({tag, "_vdrop"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    exp_t        e;
    int          n;
    logic        seen;
    logic [1:0]  rop;
    logic        rsat;
    logic [31:0] ra, rb;
    logic [63:0] racc;

    #2 i_reset = 1'b1;
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_rd", o_rd, 64'd0);
    check("rst_sat", 64'(o_sat), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;

    send(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    check("t1_busy", 64'(o_busy), 64'd1);
    sbq.push_back(mk(64'hFFFF_FFFE_0000_0001, 1'b0));
    get_result(6, "t1_umul");

    send(2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_0005, 64'd0);
    sbq.push_back(mk(64'hFFFF_FFFF_FFFF_FFFB, 1'b0));
    get_result(6, "t2_smul");
    send(2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0000_0005, 64'd0);
    sbq.push_back(mk(64'h0000_0004_FFFF_FFFB, 1'b0));
    get_result(6, "t2_umul");

    send(2'b11, 1'b1, 32'd1, 32'd1, 64'h7FFF_FFFF_FFFF_FFFF);
`ifdef ZAP_MAC_SAT_EN
    sbq.push_back(mk(64'h7FFF_FFFF_FFFF_FFFF, 1'b1));
`else
    sbq.push_back(mk(64'h8000_0000_0000_0000, 1'b0));
`endif
    get_result(6, "t3_smac");

    send(2'b11, 1'b1, 32'hFFFF_FFFF, 32'd1, 64'h8000_0000_0000_0000);
    sbq.push_back(model(2'b11, 1'b1, 32'hFFFF_FFFF, 32'd1, 64'h8000_0000_0000_0000));
    get_result(6, "smac_neg");
    send(2'b10, 1'b1, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    sbq.push_back(model(2'b10, 1'b1, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF));
    get_result(6, "umac_carry");
    send(2'b11, 1'b0, 32'd1, 32'd1, 64'h7FFF_FFFF_FFFF_FFFF);
    sbq.push_back(mk(64'h8000_0000_0000_0000, 1'b0));
    get_result(6, "smac_nosat");

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom); rsat = 1'($urandom); ra = $urandom; rb = $urandom;
      racc = {$urandom, $urandom};
      send(rop, rsat, ra, rb, racc);
      sbq.push_back(model(rop, rsat, ra, rb, racc));
      get_result(6, "rand");
    end

    // Result held under back-pressure, then zero-bubble handoff
    send(2'b00, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0);
    sbq.push_back(model(2'b00, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 64'd0));
    n = 0;
    while (!o_valid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    e = (sbq.size() > 0) ? sbq.pop_front() : mk('x, 1'bx);
    for (int i = 0; i < 4; i++) begin
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_rd", o_rd, e.rd);
      if (i < 3) @(negedge i_clk);
    end
    rop = 2'b11; rsat = 1'b1; ra = 32'h8000_0001; rb = 32'h7FFF_FFFF;
    racc = 64'h8000_0000_0000_0000;
    i_ready = 1'b1; i_valid = 1'b1; i_op = rop; i_sat = rsat; i_a = ra; i_b = rb; i_acc = racc;
    #1;
    check("b2b_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    acc_cyc = cyc;
    i_valid = 1'b0; i_ready = 1'b0;
    sbq.push_back(model(rop, rsat, ra, rb, racc));
    check("b2b_busy", 64'(o_busy), 64'd1);
    check("b2b_vlow", 64'(o_valid), 64'd0);
    get_result(6, "b2b");

    // Flush on the second MUL cycle
    send(2'b01, 1'b0, 32'h0BAD_F00D, 32'h1357_9BDF, 64'd0);
    @(negedge i_clk);
    i_clear = 1'b1;
    @(negedge i_clk);
    i_clear = 1'b0;
    check("clr_ready", 64'(o_ready), 64'd1);
    check("clr_busy", 64'(o_busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_valid) seen = 1'b1;
      @(negedge i_clk);
    end
    check("clr_no_valid", 64'(seen), 64'd0);

    // Asynchronous reset mid-operation
    send(2'b00, 1'b0, 32'hDEAD_BEEF, 32'h0000_0003, 64'd0);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check("mrst_ready", 64'(o_ready), 64'd1);
    check("mrst_busy", 64'(o_busy), 64'd0);
    check("mrst_rd", o_rd, 64'd0);
    check("mrst_valid", 64'(o_valid), 64'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (o_valid) seen = 1'b1;
      @(negedge i_clk);
    end
    check("mrst_no_valid", 64'(seen), 64'd0);

    // Four stalled cycles in MUL stretch latency to 10
    rop = 2'b01; ra = $urandom; rb = $urandom;
    send(rop, 1'b0, ra, rb, 64'd0);
    sbq.push_back(model(rop, 1'b0, ra, rb, 64'd0));
    @(negedge i_clk);
    i_stall = 1'b1;
    repeat (4) @(negedge i_clk);
    i_stall = 1'b0;
    get_result(10, "stall");

    // 24-bit instance with 8-bit tiles
    @(negedge i_clk);
    s_valid = 1'b1; s_op = 2'b01; s_a = 24'h80_0000; s_b = 24'h80_0000; s_acc = '0;
    #1;
    check("s_ready", 64'(s_ready), 64'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    acc_cyc = cyc;
    s_valid = 1'b0;
    n = 0;
    while (!s_ovalid && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    check("s_valid", 64'(s_ovalid), 64'd1);
    check("s_lat", 64'(cyc - acc_cyc), 64'd11);
    check("s_rd", 64'(s_rd), 64'h0000_4000_0000_0000);
    check("s_sat", 64'(s_osat), 64'd0);
    s_iready = 1'b1;
    @(negedge i_clk);
    s_iready = 1'b0;

    check("sb_empty", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
